// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle sequencer sitting in front of an external RV32I ALU. It accepts
// one OP / OP-IMM request in IDLE, presents registered operands and an ALU op
// code, and captures the ALU answer. The captured answer is post-processed
// where the bare ALU cannot produce the RV32I value directly (slt, and sra when
// enabled). The final value is then held until the consumer takes it.
//
// FSM: IDLE -> EXEC -> (SRA2) -> DONE -> IDLE
//
// Optional feature macro: ALU_SEQ_SRA_EN
//   defined   : funct3=101 with funct7b5=1 runs a true arithmetic shift using a
//               second ALU pass (SRA2 state).
//   undefined : funct7b5 is ignored for funct3=101, so the operation is a
//               logical shift right.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake (in_ready high only in IDLE)
//   funct3, funct7b5  : RV32I operation select (funct7b5 = instr[30])
//   is_imm            : OP-IMM form, operand B comes from imm
//   rs1_val, rs2_val  : register operands A and B
//   imm               : sign-extended immediate
//   SrcA, SrcB        : registered operands driven to the ALU
//   ALUControl        : registered ALU op code
//   ALUResult         : ALU output for the current SrcA/SrcB/ALUControl
//   EQ, GT, LT        : unsigned compare flags from the ALU
//   out_valid/out_ready : result handshake
//   result            : final 32-bit value, stable while out_valid is high
// -----------------------------------------------------------------------------
module alu_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        is_imm,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [2:0]  ALUControl,
  input  logic [31:0] ALUResult,
  input  logic        EQ,
  input  logic        GT,
  input  logic        LT,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // ALU op codes understood by the external ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
`ifdef ALU_SEQ_SRA_EN
    ST_SRA2 = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_t;

  state_t state;

  // Signed slt built from the ALU's unsigned compare: differing signs decide
  // on their own (negative A is the smaller), equal signs reduce to unsigned.
  function automatic logic [DATA_W-1:0] slt_value(input logic a_msb,
                                                   input logic b_msb,
                                                   input logic lt_u);
    logic bit_v;
    bit_v = (a_msb != b_msb) ? a_msb : lt_u;
    return {{(DATA_W-1){1'b0}}, bit_v};
  endfunction

`ifdef ALU_SEQ_SRA_EN
  // m = all-ones >> shamt, so ~m is a mask of the top shamt bits; OR-ing it
  // into the logical shift result replicates the sign bit.
  function automatic logic [DATA_W-1:0] sra_merge(input logic              neg,
                                                  input logic [DATA_W-1:0] l,
                                                  input logic [DATA_W-1:0] m);
    return neg ? (l | ~m) : l;
  endfunction
`endif

  // Only LT takes part in the signed compare; EQ/GT are part of the ALU
  // interface but carry no information this sequencer needs.
  logic unused_flags;
  assign unused_flags = EQ ^ GT;

  // Request decode (combinational, sampled on the accept edge)
  logic [DATA_W-1:0] opb_p0;
  logic [DATA_W-1:0] srcb_p0;
  logic [2:0]        ctrl_p0;
  logic              shift_p0;
  logic              slt_p0;
`ifdef ALU_SEQ_SRA_EN
  logic              sra_p0;
`endif

  always_comb begin
    opb_p0   = is_imm ? imm : rs2_val;
    ctrl_p0  = ALU_ADD;
    shift_p0 = 1'b0;
    slt_p0   = 1'b0;
`ifdef ALU_SEQ_SRA_EN
    sra_p0   = 1'b0;
`endif
    case (funct3)
      3'b000: ctrl_p0 = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        ctrl_p0  = ALU_SLL;
        shift_p0 = 1'b1;
      end
      3'b010: begin
        ctrl_p0 = ALU_SLT;
        slt_p0  = 1'b1;
      end
      3'b011: ctrl_p0 = ALU_SLT;
      3'b100: ctrl_p0 = ALU_XOR;
      3'b101: begin
        // srl and sra share the logical-shift ALU op; sra is finished in SRA2
        ctrl_p0  = ALU_SRL;
        shift_p0 = 1'b1;
`ifdef ALU_SEQ_SRA_EN
        sra_p0   = funct7b5;
`endif
      end
      3'b110: ctrl_p0 = ALU_OR;
      3'b111: ctrl_p0 = ALU_AND;
      default: ctrl_p0 = ALU_ADD;
    endcase
    // Shifts only look at the low five bits of B; the rest is cleared so the
    // ALU never sees an out-of-range shift amount.
    srcb_p0 = shift_p0 ? {{(DATA_W-SHAMT_W){1'b0}}, opb_p0[SHAMT_W-1:0]}
                       : opb_p0;
  end

  // Operation flags carried from accept into EXEC
  logic              slt_p1;
`ifdef ALU_SEQ_SRA_EN
  logic              sra_p1;
  logic              sra_neg_p2;
  logic [DATA_W-1:0] sra_lo_p2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      SrcA       <= '0;
      SrcB       <= '0;
      ALUControl <= ALU_ADD;
      slt_p1     <= 1'b0;
`ifdef ALU_SEQ_SRA_EN
      sra_p1     <= 1'b0;
      sra_neg_p2 <= 1'b0;
      sra_lo_p2  <= '0;
`endif
    end else begin
      case (state)
        // ---- IDLE -> EXEC: latch operands and decoded op ----
        ST_IDLE: begin
          if (in_valid) begin
            SrcA       <= rs1_val;
            SrcB       <= srcb_p0;
            ALUControl <= ctrl_p0;
            slt_p1     <= slt_p0;
`ifdef ALU_SEQ_SRA_EN
            sra_p1     <= sra_p0;
`endif
            in_ready   <= 1'b0;
            state      <= ST_EXEC;
          end
        end

        // ---- EXEC -> DONE / SRA2: capture first ALU pass ----
        ST_EXEC: begin
`ifdef ALU_SEQ_SRA_EN
          if (sra_p1) begin
            // Second pass shifts all-ones by the same amount to build the
            // sign-fill mask; SrcB already holds the shift amount.
            sra_lo_p2  <= ALUResult;
            sra_neg_p2 <= SrcA[DATA_W-1];
            SrcA       <= '1;
            ALUControl <= ALU_SRL;
            state      <= ST_SRA2;
          end else begin
            result    <= slt_p1 ? slt_value(SrcA[DATA_W-1], SrcB[DATA_W-1], LT)
                                : ALUResult;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
`else
          result    <= slt_p1 ? slt_value(SrcA[DATA_W-1], SrcB[DATA_W-1], LT)
                              : ALUResult;
          out_valid <= 1'b1;
          state     <= ST_DONE;
`endif
        end

`ifdef ALU_SEQ_SRA_EN
        // ---- SRA2 -> DONE: merge sign-fill mask ----
        ST_SRA2: begin
          result    <= sra_merge(sra_neg_p2, sra_lo_p2, ALUResult);
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
`endif

        // ---- DONE -> IDLE: hold result until consumer takes it ----
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
